gpr_file_sb: RTL and testbench



---
 rtl/gpr_file_sb.sv | 108 ++++++++++
 tb/tb_gpr_file_sb.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/gpr_file_sb.sv
// Register file with two combinational read ports, one byte-masked write port,
// and a per-register saturating pending-write counter for RAW stall detection.
module gpr_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int PEND_W   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   ra1,
  input  logic [ADDR_W-1:0]   ra2,
  output logic [DATA_W-1:0]   rd1,
  output logic [DATA_W-1:0]   rd2,
  output logic                busy1,
  output logic                busy2,
  input  logic                we,
  input  logic [ADDR_W-1:0]   wa,
  input  logic [DATA_W-1:0]   wd,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic                iss,
  input  logic [ADDR_W-1:0]   isa,
  output logic                sb_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;
  localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PEND_W-1:0] cnt_q [DEPTH];
  logic [PEND_W-1:0] cnt_d [DEPTH];
  logic              sb_err_q;
  logic              sb_err_d;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    cnt_d    = cnt_q;
    sb_err_d = sb_err_q;
    for (int a = 0; a < DEPTH; a++) begin
      logic hit_w;
      logic hit_i;
      hit_w = we  && (wa  == ADDR_W'(a)) && !is_zero_reg(ADDR_W'(a));
      hit_i = iss && (isa == ADDR_W'(a)) && !is_zero_reg(ADDR_W'(a));
      if (hit_w) begin
        for (int b = 0; b < NB; b++) begin
          if (wbe[b]) mem_d[a][8*b +: 8] = wd[8*b +: 8];
        end
        if (cnt_q[a] == '0) sb_err_d = 1'b1;
      end
      // A simultaneous issue and retire on one entry cancel out.
      if (hit_i && !hit_w) begin
        if (cnt_q[a] == CNT_MAX) sb_err_d = 1'b1;
        else                     cnt_d[a] = cnt_q[a] + 1'b1;
      end else if (hit_w && !hit_i && (cnt_q[a] != '0)) begin
        cnt_d[a] = cnt_q[a] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem_q[a] <= '0;
        cnt_q[a] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
    logic [DATA_W-1:0] v;
    v = mem_q[ra];
    if ((BYPASS != 0) && !reset && we && (wa == ra)) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) v[8*b +: 8] = wd[8*b +: 8];
      end
    end
    if (is_zero_reg(ra)) v = '0;
    return v;
  endfunction

  // With bypass, a retire landing this cycle already clears the consumer's stall.
  function automatic logic busy_port(input logic [ADDR_W-1:0] ra);
    logic [PEND_W-1:0] c;
    logic              ret;
    c   = cnt_q[ra];
    ret = (BYPASS != 0) && !reset && we && (wa == ra) && (c != '0);
    return !is_zero_reg(ra) && ((c - PEND_W'(ret)) != '0);
  endfunction

  assign rd1    = read_port(ra1);
  assign rd2    = read_port(ra2);
  assign busy1  = busy_port(ra1);
  assign busy2  = busy_port(ra2);
  assign sb_err = sb_err_q;

endmodule

// File: tb/tb_gpr_file_sb.sv
// Directed bench: a bypassing instance and a non-bypassing instance share stimulus.
module tb_gpr_file_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ra1, ra2, wa, isa;
  logic        we, iss;
  logic [31:0] wd;
  logic [3:0]  wbe;
  logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
  logic        busy1, busy2, nb_busy1, nb_busy2, sb_err, nb_sb_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gpr_file_sb #(.BYPASS(1)) dut (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
    .iss(iss), .isa(isa), .sb_err(sb_err)
  );

  gpr_file_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(nb_rd1), .rd2(nb_rd2),
    .busy1(nb_busy1), .busy2(nb_busy2), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
    .iss(iss), .isa(isa), .sb_err(nb_sb_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; ra1 = '0; ra2 = '0; we = 1'b0; wa = '0; wd = '0; wbe = '0;
    iss = 1'b0; isa = '0;
    tick(); tick();
    reset = 1'b0;
    settle();

    // Reset state across every address
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(31 - a);
      settle();
      check($sformatf("rst_rd1_%0d", a), rd1, 32'h0);
      check($sformatf("rst_rd2_%0d", a), rd2, 32'h0);
      check($sformatf("rst_busy1_%0d", a), {31'h0, busy1}, 32'h0);
      check($sformatf("rst_busy2_%0d", a), {31'h0, busy2}, 32'h0);
    end
    check("rst_sb_err", {31'h0, sb_err}, 32'h0);

    // Zero register: no bypass, no write, no busy, no error
    ra1 = 5'd0; we = 1'b1; wa = 5'd0; wd = 32'hDEADBEEF; wbe = 4'hF;
    iss = 1'b1; isa = 5'd0;
    settle();
    check("r0_bypass", rd1, 32'h0);
    tick();
    we = 1'b0; iss = 1'b0;
    settle();
    check("r0_after", rd1, 32'h0);
    check("r0_busy", {31'h0, busy1}, 32'h0);
    check("r0_sb_err", {31'h0, sb_err}, 32'h0);

    // Full-word write with bypass, then byte-masked write
    ra1 = 5'd5; ra2 = 5'd5; we = 1'b1; wa = 5'd5; wd = 32'h12345678; wbe = 4'hF;
    settle();
    check("byp_full", rd1, 32'h12345678);
    check("byp_full_rd2", rd2, 32'h12345678);
    check("nb_full_old", nb_rd1, 32'h0);
    tick();
    wd = 32'hFFFFFFFF; wbe = 4'b0010;
    settle();
    check("byp_byte", rd1, 32'h1234FF78);
    check("nb_byte_old", nb_rd1, 32'h12345678);
    tick();
    we = 1'b0;
    settle();
    check("byte_stored", rd1, 32'h1234FF78);
    check("nb_byte_stored", nb_rd1, 32'h1234FF78);
    // Those writes had no issued pending count: underflow
    check("underflow_err", {31'h0, sb_err}, 32'h1);

    // Reset with a write pending: no bypass, write ignored
    reset = 1'b1;
    tick();
    we = 1'b1; wa = 5'd5; wd = 32'h0BADF00D; wbe = 4'hF;
    settle();
    check("rst_no_bypass", rd1, 32'h0);
    tick();
    reset = 1'b0; we = 1'b0;
    settle();
    check("rst_write_ignored", rd1, 32'h0);
    check("rst_clears_err", {31'h0, sb_err}, 32'h0);

    // Two issues to $8 then two retires
    ra1 = 5'd8; iss = 1'b1; isa = 5'd8;
    settle();
    check("iss_no_busy_same_cycle", {31'h0, busy1}, 32'h0);
    tick();
    check("iss1_busy", {31'h0, busy1}, 32'h1);
    tick();
    iss = 1'b0; we = 1'b1; wa = 5'd8; wbe = 4'h0;
    settle();
    check("ret1_busy", {31'h0, busy1}, 32'h1);
    check("nb_ret1_busy", {31'h0, nb_busy1}, 32'h1);
    tick();
    settle();
    check("ret2_busy_comb", {31'h0, busy1}, 32'h0);
    check("nb_ret2_busy_comb", {31'h0, nb_busy1}, 32'h1);
    tick();
    we = 1'b0;
    settle();
    check("ret2_busy_after", {31'h0, busy1}, 32'h0);
    check("nb_ret2_busy_after", {31'h0, nb_busy1}, 32'h0);
    check("ret_sb_err", {31'h0, sb_err}, 32'h0);

    // Same-cycle issue and retire on $9 with count 1
    ra1 = 5'd9; iss = 1'b1; isa = 5'd9;
    tick();
    we = 1'b1; wa = 5'd9;
    tick();
    iss = 1'b0; we = 1'b0;
    settle();
    check("iss_we_busy", {31'h0, busy1}, 32'h1);
    check("iss_we_sb_err", {31'h0, sb_err}, 32'h0);
    we = 1'b1;
    tick();
    we = 1'b0;
    settle();
    check("iss_we_cnt_one", {31'h0, busy1}, 32'h0);
    check("iss_we_final_err", {31'h0, sb_err}, 32'h0);

    // Saturation on $3
    ra1 = 5'd3; iss = 1'b1; isa = 5'd3;
    tick(); tick(); tick();
    settle();
    check("sat3_no_err", {31'h0, sb_err}, 32'h0);
    tick();
    iss = 1'b0;
    settle();
    check("sat_err", {31'h0, sb_err}, 32'h1);
    check("sat_busy", {31'h0, busy1}, 32'h1);
    we = 1'b1; wa = 5'd3; wbe = 4'h0;
    tick(); tick();
    we = 1'b0;
    settle();
    check("sat_two_retired", {31'h0, busy1}, 32'h1);
    we = 1'b1;
    tick();
    we = 1'b0;
    settle();
    check("sat_count_was_3", {31'h0, busy1}, 32'h0);

    // Underflow write to $4 still stores data
    ra2 = 5'd4; we = 1'b1; wa = 5'd4; wd = 32'hA5A5A5A5; wbe = 4'hF;
    tick();
    we = 1'b0;
    settle();
    check("uf_data", rd2, 32'hA5A5A5A5);
    check("uf_err_sticky", {31'h0, sb_err}, 32'h1);

    // Reset clears everything
    iss = 1'b1; isa = 5'd3;
    tick();
    iss = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check("final_err_clr", {31'h0, sb_err}, 32'h0);
    check("final_rd2", rd2, 32'h0);
    check("final_busy1", {31'h0, busy1}, 32'h0);
    check("final_nb_err", {31'h0, nb_sb_err}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
